uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters sharing the single UART transmitter.
REQ-002 Parameter BUSY_WAIT_CYCLES, default 20000: maximum Clock_100MHz cycles from TX_en rising to TX_busy high.
REQ-003 Parameter FRAME_MAX_CYCLES, default 200000: maximum Clock_100MHz cycles that TX_busy may stay high per byte.
REQ-004 Clock_100MHz  in  1  sole clock; all logic on its rising edge.
REQ-005 Reset  in  1  reset, synchronous, active-high.
REQ-006 Req  in  NUM_REQ  per-requester level request; bit i high = byte on Req_data slice i is valid.
REQ-007 Req_data  in  8*NUM_REQ  requester i byte at bits [8i+7:8i].
REQ-008 Ack  out  NUM_REQ  one-cycle pulse: requester i byte captured; requester may drop or change Req/Req_data from the next cycle.
REQ-009 Done  out  NUM_REQ  one-cycle pulse: requester i byte fully transmitted.
REQ-010 TX_data  out  8  byte to UART transmitter, held stable from capture until return to IDLE.
REQ-011 TX_en  out  1  transmit request to UART transmitter, level.
REQ-012 TX_busy  in  1  transmitter busy flag, high while a frame is on the line.
REQ-013 Active_id  out  clog2(NUM_REQ)  index of requester currently owning the transmitter.
REQ-014 Timeout_err  out  1  sticky error flag.

Function
REQ-015 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE; encoding comes from the shared package.
REQ-016 IDLE: when any Req bit is high, the scheduler selects a winner round-robin, registers TX_data and Active_id, and enters LAUNCH; Ack[winner] is high during the LAUNCH cycle.
REQ-017 Round-robin: search starts at (last served index + 1) mod NUM_REQ; after reset it starts at 0; the pointer advances after every completed or timed-out byte.
REQ-018 LAUNCH: TX_en goes high, the cycle counter clears, and the FSM enters WAIT_BUSY (LAUNCH lasts exactly 1 cycle).
REQ-019 WAIT_BUSY: TX_en stays high until TX_busy is sampled high, then TX_en drops and the FSM enters WAIT_DONE with the counter cleared.
REQ-020 WAIT_DONE: on TX_busy sampled low, Done[Active_id] pulses for 1 cycle and the FSM returns to IDLE.
REQ-021 Minimum spacing: there is at least 1 IDLE cycle between a Done pulse and the next Ack.
REQ-022 Timeout, WAIT_BUSY: if the counter reaches BUSY_WAIT_CYCLES with TX_busy low, TX_en drops, Timeout_err sets, no Done is issued, and the FSM returns to IDLE.
REQ-023 Timeout, WAIT_DONE: if the counter reaches FRAME_MAX_CYCLES with TX_busy high, Timeout_err sets, no Done is issued, and the FSM returns to IDLE.
REQ-024 Counter width: clog2(FRAME_MAX_CYCLES+1) bits, saturating, with no wrap.
REQ-025 Req bits that drop before they are granted are ignored, with no side effects; Req_data is sampled only in the IDLE grant cycle.
REQ-026 Req still high on return to IDLE is treated as a new request.
REQ-027 Simultaneous requests: exactly one Ack bit is high per grant; Ack and Done are never both high in the same cycle.
REQ-028 Timeout_err clears only on Reset.

Reset
REQ-029 Reset sets, on the next edge: state IDLE, TX_en=0, TX_data=0, Ack=0, Done=0, Active_id=0, Timeout_err=0, counter=0, RR pointer so requester 0 has top priority.
REQ-030 Reset mid-operation in any state aborts the byte with no Done, and TX_en drops on that edge.
REQ-031 Reset dominates all other inputs in the same cycle.

Structure
REQ-032 Shared package uart_ctrl_pkg holds NUM_REQ default, byte width 8, FSM state encoding, and the BUSY_WAIT_CYCLES and FRAME_MAX_CYCLES defaults.
REQ-033 Sub-module rr_arbiter: combinational round-robin select from Req and pointer, producing a one-hot grant and an index; pointer register stays in uart_tx_scheduler.
REQ-034 There are no other sub-modules, and the scheduler never touches baud generation.

Verification
REQ-035 Single request: Req=4'b0001, Req_data[7:0]=8'h41; TX_busy model goes high 5 cycles after TX_en and stays high 1000 cycles -> Ack[0] at T+1, TX_data=8'h41, TX_en high 6 cycles, Done[0] 1 cycle after TX_busy falls.
REQ-036 Contention: Req=4'b1111 held continuously with distinct bytes 8'h30..8'h33 -> grant order 0,1,2,3,0, and each Ack follows the previous Done by at least 2 cycles.
REQ-037 Busy timeout: TX_busy tied 0 -> TX_en high exactly BUSY_WAIT_CYCLES cycles, Timeout_err=1, no Done; the next request is still served.
REQ-038 Frame timeout: TX_busy stuck 1 after launch -> Timeout_err=1 after FRAME_MAX_CYCLES cycles, FSM returns to IDLE, no Done.
REQ-039 Reset in WAIT_DONE: all outputs 0 and the RR pointer reset on the next edge; after release, Req=4'b0110 grants requester 1 first.
REQ-040 Withdrawn request: Req[2] pulses high while requester 0 owns the transmitter, and drops before the return to IDLE -> no Ack[2] and no TX of requester 2 data.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit scheduler: defaults, byte width,
// FSM state encoding and an index-width helper.
package uart_ctrl_pkg;

    localparam int unsigned NUM_REQ_DEF          = 4;
    localparam int unsigned BYTE_W               = 8;
    localparam int unsigned BUSY_WAIT_CYCLES_DEF = 20000;
    localparam int unsigned FRAME_MAX_CYCLES_DEF = 200000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_t;

    // Index width that stays legal for a single requester.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: the first set request at or after 'start',
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     start,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               valid
);

    always_comb begin
        logic [IDW-1:0] cand;
        cand  = '0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = IDW'((32'(start) + off) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte requesters with round-robin
// arbitration, launch/busy handshaking and sticky timeout detection.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ          = NUM_REQ_DEF,
    parameter int unsigned BUSY_WAIT_CYCLES = BUSY_WAIT_CYCLES_DEF,
    parameter int unsigned FRAME_MAX_CYCLES = FRAME_MAX_CYCLES_DEF
) (
    input  logic                            Clock_100MHz,
    input  logic                            Reset,
    input  logic [NUM_REQ-1:0]              Req,
    input  logic [BYTE_W*NUM_REQ-1:0]       Req_data,
    output logic [NUM_REQ-1:0]              Ack,
    output logic [NUM_REQ-1:0]              Done,
    output logic [BYTE_W-1:0]               TX_data,
    output logic                            TX_en,
    input  logic                            TX_busy,
    output logic [id_width(NUM_REQ)-1:0]    Active_id,
    output logic                            Timeout_err
);

    localparam int unsigned    IDW       = id_width(NUM_REQ);
    localparam int unsigned    CW        = $clog2(FRAME_MAX_CYCLES + 1);
    localparam logic [CW-1:0]  BUSY_LIM  = CW'(BUSY_WAIT_CYCLES - 1);
    localparam logic [CW-1:0]  FRAME_LIM = CW'(FRAME_MAX_CYCLES - 1);

    tx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       next_ptr;
    logic [CW-1:0]        cnt_inc;
    logic [NUM_REQ-1:0]   win_grant;
    logic [IDW-1:0]       win_idx;
    logic                 win_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_arbiter (
        .req   (Req),
        .start (rr_ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // rr_ptr holds the index where the next search starts (last served + 1).
    always_comb begin
        next_ptr = (Active_id == IDW'(NUM_REQ - 1)) ? '0 : Active_id + IDW'(1);
        cnt_inc  = (cnt == '1) ? cnt : cnt + CW'(1);
    end

    always_ff @(posedge Clock_100MHz) begin
        if (Reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rr_ptr      <= '0;
            Ack         <= '0;
            Done        <= '0;
            TX_data     <= '0;
            TX_en       <= 1'b0;
            Active_id   <= '0;
            Timeout_err <= 1'b0;
        end else begin
            Ack  <= '0;
            Done <= '0;
            case (state)
                ST_IDLE: begin
                    // The cycle carrying Done is skipped so a grant never follows it directly.
                    if (win_valid && Done == '0) begin
                        TX_data   <= Req_data[BYTE_W*win_idx +: BYTE_W];
                        Active_id <= win_idx;
                        Ack       <= win_grant;
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    TX_en <= 1'b1;
                    cnt   <= '0;
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (TX_busy) begin
                        TX_en <= 1'b0;
                        cnt   <= '0;
                        state <= ST_WAIT_DONE;
                    end else if (cnt >= BUSY_LIM) begin
                        TX_en       <= 1'b0;
                        Timeout_err <= 1'b1;
                        rr_ptr      <= next_ptr;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!TX_busy) begin
                        Done[Active_id] <= 1'b1;
                        rr_ptr          <= next_ptr;
                        state           <= ST_IDLE;
                    end else if (cnt >= FRAME_LIM) begin
                        Timeout_err <= 1'b1;
                        rr_ptr      <= next_ptr;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a hand-driven TX_busy transmitter model.
module tb_uart_tx_scheduler;

    logic        clk;
    logic        Reset;
    logic [3:0]  Req;
    logic [31:0] Req_data;
    logic [3:0]  Ack;
    logic [3:0]  Done;
    logic [7:0]  TX_data;
    logic        TX_en;
    logic        TX_busy;
    logic [1:0]  Active_id;
    logic        Timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done = -1;

    uart_tx_scheduler #(
        .NUM_REQ          (4),
        .BUSY_WAIT_CYCLES (20),
        .FRAME_MAX_CYCLES (2000)
    ) dut (
        .Clock_100MHz (clk),
        .Reset        (Reset),
        .Req          (Req),
        .Req_data     (Req_data),
        .Ack          (Ack),
        .Done         (Done),
        .TX_data      (TX_data),
        .TX_en        (TX_en),
        .TX_busy      (TX_busy),
        .Active_id    (Active_id),
        .Timeout_err  (Timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        while (Ack == '0 && n < 20) begin tick(); n++; end
        chk(tag, 32'(n < 20), 32'd1);
    endtask

    task automatic wait_txen(input string tag);
        int n = 0;
        while (!TX_en && n < 20) begin tick(); n++; end
        chk(tag, 32'(n < 20), 32'd1);
    endtask

    task automatic serve(input int dly, input int len, output int idx);
        int n;
        wait_ack("serve_ack_seen");
        idx = 0;
        for (int i = 0; i < 4; i++) if (Ack[i]) idx = i;
        chk("serve_ack_onehot", 32'($countones(Ack)), 32'd1);
        if (last_done >= 0) chk("serve_ack_spacing", 32'((cyc - last_done) >= 2), 32'd1);
        wait_txen("serve_txen_seen");
        repeat (dly) tick();
        TX_busy = 1'b1;
        repeat (len) tick();
        TX_busy = 1'b0;
        n = 0;
        while (Done == '0 && n < 20) begin tick(); n++; end
        chk("serve_done_seen", 32'(n < 20), 32'd1);
        chk("serve_done_id", 32'(Done), 32'd1 << idx);
        chk("serve_done_no_ack", 32'(Ack), 32'd0);
        last_done = cyc;
    endtask

    initial begin
        int n;
        int idx;
        logic seen;
        logic seen2;

        Reset = 1'b1; Req = '0; Req_data = '0; TX_busy = 1'b0;
        tick(); tick();
        chk("rst_ack", 32'(Ack), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_txen", 32'(TX_en), 0);
        chk("rst_txdata", 32'(TX_data), 0);
        chk("rst_active", 32'(Active_id), 0);
        chk("rst_timeout", 32'(Timeout_err), 0);
        Reset = 1'b0;
        tick();

        // Single request
        Req = 4'b0001; Req_data[7:0] = 8'h41;
        tick();
        chk("single_ack", 32'(Ack), 32'h1);
        chk("single_txdata", 32'(TX_data), 32'h41);
        chk("single_active", 32'(Active_id), 0);
        chk("single_txen_launch", 32'(TX_en), 0);
        Req = '0;
        tick();
        n = 0;
        repeat (5) begin if (TX_en) n++; tick(); end
        TX_busy = 1'b1;
        if (TX_en) n++;
        tick();
        chk("single_txen_cycles", 32'(n), 32'd6);
        chk("single_txen_drop", 32'(TX_en), 0);
        seen = 1'b0;
        repeat (999) begin tick(); if (Done != '0) seen = 1'b1; end
        chk("single_no_early_done", 32'(seen), 0);
        TX_busy = 1'b0;
        tick();
        chk("single_done", 32'(Done), 32'h1);
        tick();
        chk("single_done_pulse", 32'(Done), 0);

        // Contention: fresh reset so the search starts at requester 0
        Reset = 1'b1; tick(); Reset = 1'b0; last_done = -1;
        Req = 4'b1111; Req_data = 32'h33323130;
        for (int k = 0; k < 5; k++) begin
            serve(2, 3, idx);
            chk("rr_order", 32'(idx), 32'(k % 4));
            chk("rr_data", 32'(TX_data), 32'h30 + 32'(k % 4));
        end
        Req = '0;
        repeat (3) tick();

        // Busy timeout with TX_busy tied low
        Req = 4'b0001; Req_data[7:0] = 8'h41;
        wait_ack("bto_ack_seen");
        chk("bto_ack", 32'(Ack), 32'h1);
        Req = '0;
        wait_txen("bto_txen_seen");
        n = 0; seen = 1'b0;
        while (TX_en && n < 100) begin n++; tick(); if (Done != '0) seen = 1'b1; end
        chk("bto_txen_cycles", 32'(n), 32'd20);
        chk("bto_timeout_err", 32'(Timeout_err), 1);
        repeat (5) begin tick(); if (Done != '0) seen = 1'b1; end
        chk("bto_no_done", 32'(seen), 0);
        Req = 4'b0010; Req_data[15:8] = 8'h55;
        serve(2, 3, idx);
        chk("bto_next_served", 32'(idx), 1);
        chk("bto_next_data", 32'(TX_data), 32'h55);
        chk("bto_err_sticky", 32'(Timeout_err), 1);
        Req = '0;
        repeat (3) tick();

        // Withdrawn request from requester 2 while 0 owns the transmitter
        Req = 4'b0001; Req_data[7:0] = 8'h41;
        wait_ack("wd_ack_seen");
        chk("wd_ack", 32'(Ack), 32'h1);
        Req = '0;
        wait_txen("wd_txen_seen");
        Req = 4'b0100; Req_data[23:16] = 8'h77;
        tick(); tick();
        TX_busy = 1'b1;
        tick(); tick();
        Req = '0;
        tick();
        TX_busy = 1'b0;
        n = 0;
        while (Done == '0 && n < 20) begin tick(); n++; end
        chk("wd_done", 32'(Done), 32'h1);
        seen = 1'b0; seen2 = 1'b0;
        repeat (20) begin tick(); if (Ack != '0) seen = 1'b1; if (TX_en) seen2 = 1'b1; end
        chk("wd_no_ack", 32'(seen), 0);
        chk("wd_no_txen", 32'(seen2), 0);
        chk("wd_txdata", 32'(TX_data), 32'h41);

        // Frame timeout with TX_busy stuck high
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("fto_err_cleared", 32'(Timeout_err), 0);
        Req = 4'b0100; Req_data[23:16] = 8'h66;
        wait_ack("fto_ack_seen");
        chk("fto_ack", 32'(Ack), 32'h4);
        Req = '0;
        wait_txen("fto_txen_seen");
        TX_busy = 1'b1;
        n = 0;
        while (TX_en && n < 20) begin tick(); n++; end
        chk("fto_txen_drop", 32'(TX_en), 0);
        n = 0; seen = 1'b0;
        while (!Timeout_err && n < 3000) begin tick(); n++; if (Done != '0) seen = 1'b1; end
        chk("fto_cycles", 32'(n), 32'd2000);
        TX_busy = 1'b0;
        tick();
        if (Done != '0) seen = 1'b1;
        chk("fto_no_done", 32'(seen), 0);

        // Reset while in WAIT_DONE, with requests present during reset
        Req = 4'b0010; Req_data[15:8] = 8'h5A;
        wait_ack("rwd_ack_seen");
        chk("rwd_ack", 32'(Ack), 32'h2);
        Req = '0;
        wait_txen("rwd_txen_seen");
        TX_busy = 1'b1;
        tick(); tick();
        Reset = 1'b1; Req = 4'b0110;
        tick();
        chk("rwd_txen", 32'(TX_en), 0);
        chk("rwd_ack0", 32'(Ack), 0);
        chk("rwd_done", 32'(Done), 0);
        chk("rwd_txdata", 32'(TX_data), 0);
        chk("rwd_active", 32'(Active_id), 0);
        chk("rwd_timeout", 32'(Timeout_err), 0);
        Reset = 1'b0; TX_busy = 1'b0;
        wait_ack("rwd_post_ack_seen");
        chk("rwd_post_grant", 32'(Ack), 32'h2);
        Req = '0;
        repeat (30) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
